// File: rtl/spi_slave_tx_fifo.sv
// First-word fall-through transmit FIFO between the AXI plug and the SPI shifter.
// Define SPI_SLAVE_TX_FIFO_LEVEL_EN to drive the level/almost_full occupancy outputs.
module spi_slave_tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  input  logic                    flush_i,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;

  // Ready never looks at out_ready, so a full FIFO cannot write through.
  assign in_ready  = (count_q != FULL) & ~flush_i;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; pointers and count alone define what is valid.
  always_ff @(posedge axi_aclk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef SPI_SLAVE_TX_FIFO_LEVEL_EN
  localparam logic [CW-1:0] AFULL = CW'(DEPTH - 1);
  assign level       = count_q;
  assign almost_full = (count_q >= AFULL);
`else
  assign level       = '0;
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_tx_fifo.sv
// Bench for spi_slave_tx_fifo: directed vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_spi_slave_tx_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] level;
  logic          almost_full;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] q[$];

  spi_slave_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .axi_aclk(clk), .axi_areset(rst), .flush_i(flush_i),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          fl;
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          er;
    logic          ev;
    logic [DW-1:0] ed;
    int            el;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  function automatic logic [DW-1:0] exp_lvl(input int n);
`ifdef SPI_SLAVE_TX_FIFO_LEVEL_EN
    return DW'(n);
`else
    return (n < 0) ? '1 : '0;
`endif
  endfunction

  function automatic logic exp_af(input int n);
`ifdef SPI_SLAVE_TX_FIFO_LEVEL_EN
    return n >= DEPTH - 1;
`else
    return (n < 0);
`endif
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated from the behavioural rules.
  task automatic model_step(input logic fl, input logic v, input logic [DW-1:0] d, input logic r);
    bit pu, po;
    pu = v && !fl && (q.size() < DEPTH);
    po = r && (q.size() > 0);
    if (fl) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(d);
    end
  endtask

  task automatic mcycle(input logic fl, input logic v, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    flush_i = fl; in_valid = v; in_data = d; out_ready = r;
    #1;
    chk("m_in_ready", {31'b0, in_ready}, {31'b0, (q.size() != DEPTH) && !fl});
    chk("m_out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) chk("m_out_data", out_data, q[0]);
    chk("m_level", DW'(level), exp_lvl(q.size()));
    chk("m_almost_full", {31'b0, almost_full}, {31'b0, exp_af(q.size())});
    @(posedge clk);
    model_step(fl, v, d, r);
  endtask

  initial begin
    // Directed table: reset-release, single push/pop, fill to full, refused 9th write.
    tbl[0] = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 32'h0, 0};
    tbl[1] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 1};
    tbl[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 1};
    tbl[3] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 0};
    for (int i = 0; i < DEPTH; i++)
      tbl[4+i] = '{1'b0, 1'b1, DW'(i), 1'b0, 1'b1, (i > 0), 32'h0, i};
    tbl[12] = '{1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 32'h0, DEPTH};

    // Outputs while reset is held.
    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_level", DW'(level), 32'h0);
    chk("rst_almost_full", {31'b0, almost_full}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      flush_i = tbl[i].fl; in_valid = tbl[i].v; in_data = tbl[i].d; out_ready = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].er});
      chk($sformatf("tbl%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_level", i), DW'(level), exp_lvl(tbl[i].el));
      chk($sformatf("tbl%0d_almost_full", i), {31'b0, almost_full}, {31'b0, exp_af(tbl[i].el)});
      @(posedge clk);
      model_step(tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].r);
    end

    // Full: single pop with in_valid held, then the new word wraps to entry 0.
    mcycle(1'b0, 1'b1, 32'h100, 1'b1);
    mcycle(1'b0, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) mcycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Level 3 with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 3; i++) mcycle(1'b0, 1'b1, 32'h200 + DW'(i), 1'b0);
    for (int i = 3; i < 23; i++) mcycle(1'b0, 1'b1, 32'h200 + DW'(i), 1'b1);
    chk("steady_depth", DW'(q.size()), 32'd3);
    for (int i = 0; i < 4; i++) mcycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Level 5, then flush together with push and pop.
    for (int i = 0; i < 5; i++) mcycle(1'b0, 1'b1, 32'h300 + DW'(i), 1'b0);
    mcycle(1'b1, 1'b1, 32'hDEAD, 1'b1);
    mcycle(1'b1, 1'b1, 32'hBEEF, 1'b0);
    mcycle(1'b0, 1'b0, 32'h0, 1'b0);
    mcycle(1'b0, 1'b1, 32'h55, 1'b0);
    mcycle(1'b0, 1'b0, 32'h0, 1'b1);
    mcycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Level 4, asynchronous reset between edges.
    for (int i = 0; i < 4; i++) mcycle(1'b0, 1'b1, 32'h400 + DW'(i), 1'b0);
    @(negedge clk);
    flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("arst_level", DW'(level), 32'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    mcycle(1'b0, 1'b1, 32'h777, 1'b0);
    mcycle(1'b0, 1'b0, 32'h0, 1'b1);
    mcycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      mcycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0), $urandom, $urandom_range(0, 1) == 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_tx_fifo.md
SPI_SLAVE_TX_FIFO -- requirements
Module: spi_slave_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each stored word.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries; power of two, at least 2.
REQ-003 SHALL have port axi_aclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port axi_areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush_i, input, 1 bit: synchronous clear, driven from the SPI chip-select (cs) high.
REQ-006 SHALL have port in_data, input, DATA_WIDTH bits: write data from the AXI plug (its tx_data).
REQ-007 SHALL have port in_valid, input, 1 bit: write request (plug's tx_valid).
REQ-008 SHALL have port in_ready, output, 1 bit: write accept (to plug's tx_ready).
REQ-009 SHALL have port out_data, output, DATA_WIDTH bits: head word, to the SPI transmit shifter.
REQ-010 SHALL have port out_valid, output, 1 bit: head word present.
REQ-011 SHALL have port out_ready, input, 1 bit: shifter takes the head word.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1 bits: occupancy.
REQ-013 SHALL have port almost_full, output, 1 bit: level >= DEPTH-1.

Function
REQ-014 SHALL implement a circular buffer: write pointer, read pointer (each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0), and count (0..DEPTH).
REQ-015 SHALL compute push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-016 SHALL drive in_ready = (count != DEPTH) & !flush_i; in_ready SHALL NOT depend on out_ready, so there is no write-through when full.
REQ-017 SHALL drive out_valid = (count != 0), with out_data = mem[rd_ptr] combinationally (first-word fall-through).
REQ-018 SHALL have no combinational path from in_valid or in_data to out_valid or out_data; a pushed word appears at the output 1 cycle after push.
REQ-019 On push only: write mem[wr_ptr], increment wr_ptr, count +1.
REQ-020 On pop only: increment rd_ptr, count -1.
REQ-021 On push and pop in the same cycle (count between 1 and DEPTH-1): advance both pointers; count unchanged.
REQ-022 When empty: pop impossible (out_valid = 0); out_data is don't-care.
REQ-023 When full: push impossible; a pop frees one entry, so in_ready = 1 on the next cycle.
REQ-024 Flush: with flush_i = 1, the next edge SHALL set wr_ptr = rd_ptr = count = 0; flush overrides push and pop in the same cycle; out_valid SHALL still follow count during the flush cycle.
REQ-025 While flush_i stays high, the FIFO SHALL remain empty and refuse writes.
REQ-026 Memory contents need no reset or clear; only the pointers and count define validity.

Reset
REQ-027 axi_areset high SHALL asynchronously force wr_ptr = rd_ptr = count = 0 regardless of the clock.
REQ-028 During reset, outputs SHALL be: in_ready = 1 (unless flush_i), out_valid = 0, level = 0, almost_full = 0.
REQ-029 Reset asserted mid-transfer SHALL discard all stored words; the first push after release lands in entry 0.

Configuration
REQ-030 Macro SPI_SLAVE_TX_FIFO_LEVEL_EN: when defined, level = count and almost_full = (count >= DEPTH-1).
REQ-031 When SPI_SLAVE_TX_FIFO_LEVEL_EN is undefined, level and almost_full SHALL be tied to 0 and their logic omitted; the port list is unchanged, and all other behaviour is identical.

Verification
REQ-032 Reset, then push 0xA5A5_0001 -> out_valid = 1 exactly 1 cycle later with out_data = 0xA5A5_0001; level = 1 (macro on).
REQ-033 Push 8 words 0x0..0x7 with out_ready = 0 -> in_ready = 0 after the 8th push; almost_full = 1 from level 7; a 9th in_valid is not accepted.
REQ-034 Full FIFO, hold in_valid = 1 and pulse out_ready for 1 cycle -> 0x0 popped; in_ready = 1 the next cycle; new word stored at wrapped wr_ptr 0; read order is 0x1..0x7 then the new word.
REQ-035 Level 3, push and pop together for 20 cycles with an incrementing pattern -> level stays 3; output sequence strictly in order; no loss across pointer wrap.
REQ-036 Level 5, assert flush_i together with in_valid and out_ready -> next cycle level = 0, out_valid = 0, no pop counted, written word absent.
REQ-037 Assert axi_areset asynchronously between clock edges with level 4 -> out_valid drops immediately; after release, the first push/pop returns only the new data.
